// File: rtl/backtrack_pkg.sv
// Shared types and constants for the bumper-recovery steering sequencer.
package backtrack_pkg;

    localparam int SERVO_W = 8;
    localparam logic [SERVO_W-1:0] SERVO_CENTER = 8'd128;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        REVERSE  = 3'd2,
        TURN     = 3'd3,
        COOLDOWN = 3'd4
    } seq_state_t;

endpackage

// File: rtl/backtrack_sequencer_ms_tick_gen.sv
// Free-running millisecond prescaler: tick is high for one cycle each time the
// counter wraps from CLK_HZ/1000-1 back to 0.
module ms_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = CLK_HZ / 1000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/backtrack_sequencer.sv
// Steering arbiter: passes SPI joystick commands to the servos and overrides them
// with a REVERSE/TURN/COOLDOWN manoeuvre on a debounced double-bumper hit.
// Optional BACKTRACK_STATS_EN adds saturating episode/abort counters.
// Handshake: spi_valid and out_valid are single-cycle strobes with no back-pressure;
// data on spi_x/spi_y is taken only in a cycle where spi_valid is high.
module backtrack_sequencer
    import backtrack_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int REVERSE_MS  = 3000,
    parameter int TURN_MS     = 2000,
    parameter int COOLDOWN_MS = 500,
    parameter logic [SERVO_W-1:0] REV_Y    = 8'd40,
    parameter logic [SERVO_W-1:0] TURN_L_X = 8'd60,
    parameter logic [SERVO_W-1:0] TURN_R_X = 8'd196
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_bumper,
    input  logic               y_bumper,
    input  logic [SERVO_W-1:0] spi_x,
    input  logic [SERVO_W-1:0] spi_y,
    input  logic               spi_valid,
    output logic [SERVO_W-1:0] out_x,
    output logic [SERVO_W-1:0] out_y,
    output logic               out_valid,
    output logic               backtrack_active,
    output logic [2:0]         seq_state
`ifdef BACKTRACK_STATS_EN
    ,
    output logic [7:0]         bump_count,
    output logic [7:0]         abort_count
`endif
);

    // A state lasting N ms exits on the tick that would take the count to N.
    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_MS - 1);
    localparam logic [15:0] REV_LAST = 16'(REVERSE_MS - 1);
    localparam logic [15:0] TRN_LAST = 16'(TURN_MS - 1);
    localparam logic [15:0] CD_LAST  = 16'(COOLDOWN_MS - 1);

    seq_state_t         state, state_nx;
    logic [15:0]        ms_cnt, ms_cnt_nx;
    logic [SERVO_W-1:0] out_x_nx, out_y_nx;
    logic               out_valid_nx;
    logic               turn_dir, turn_dir_nx;
    logic               ms_tick;
    logic               pass;
    logic               both;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (ms_tick)
    );

    assign both = x_bumper & y_bumper;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ms_cnt           <= '0;
            out_x            <= SERVO_CENTER;
            out_y            <= SERVO_CENTER;
            out_valid        <= 1'b0;
            backtrack_active <= 1'b0;
            turn_dir         <= 1'b0;
        end else begin
            state            <= state_nx;
            ms_cnt           <= ms_cnt_nx;
            out_x            <= out_x_nx;
            out_y            <= out_y_nx;
            out_valid        <= out_valid_nx;
            backtrack_active <= (state_nx == REVERSE) || (state_nx == TURN);
            turn_dir         <= turn_dir_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        ms_cnt_nx    = ms_tick ? ms_cnt + 16'd1 : ms_cnt;
        out_x_nx     = out_x;
        out_y_nx     = out_y;
        out_valid_nx = 1'b0;
        turn_dir_nx  = turn_dir;
        pass         = 1'b0;

        case (state)
            IDLE: begin
                pass = 1'b1;
                if (both) state_nx = DEBOUNCE;
            end
            DEBOUNCE: begin
                pass = 1'b1;
                if (!both) state_nx = IDLE;
                else if (ms_tick && ms_cnt == DEB_LAST) state_nx = REVERSE;
            end
            REVERSE: begin
                out_valid_nx = ms_tick;
                if (ms_tick && ms_cnt == REV_LAST) state_nx = TURN;
            end
            TURN: begin
                out_valid_nx = ms_tick;
                if (ms_tick && ms_cnt == TRN_LAST) begin
                    state_nx    = COOLDOWN;
                    turn_dir_nx = ~turn_dir;
                end
            end
            COOLDOWN: begin
                pass = 1'b1;
                if (ms_tick && ms_cnt == CD_LAST) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (pass && spi_valid) begin
            out_x_nx     = spi_x;
            out_y_nx     = spi_y;
            out_valid_nx = 1'b1;
        end

        // Entry actions come last so the override beats same-cycle SPI data.
        if (state_nx != state) begin
            ms_cnt_nx = '0;
            case (state_nx)
                REVERSE: begin
                    out_x_nx     = SERVO_CENTER;
                    out_y_nx     = REV_Y;
                    out_valid_nx = 1'b1;
                end
                TURN: begin
                    out_x_nx     = turn_dir ? TURN_R_X : TURN_L_X;
                    out_y_nx     = SERVO_CENTER;
                    out_valid_nx = 1'b1;
                end
                COOLDOWN: begin
                    out_x_nx     = SERVO_CENTER;
                    out_y_nx     = SERVO_CENTER;
                    out_valid_nx = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign seq_state = state;

`ifdef BACKTRACK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bump_count  <= '0;
            abort_count <= '0;
        end else begin
            if (state == TURN && state_nx == COOLDOWN && bump_count != 8'hFF)
                bump_count <= bump_count + 8'd1;
            if (state == DEBOUNCE && state_nx == IDLE && abort_count != 8'hFF)
                abort_count <= abort_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_backtrack_sequencer.sv
// Directed self-checking bench for backtrack_sequencer at 10 cycles/ms; the stats
// checks run only when BACKTRACK_STATS_EN is defined.
module tb_backtrack_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x_bumper = 1'b0;
    logic       y_bumper = 1'b0;
    logic [7:0] spi_x = 8'h00;
    logic [7:0] spi_y = 8'h00;
    logic       spi_valid = 1'b0;
    logic [7:0] out_x, out_y;
    logic       out_valid, backtrack_active;
    logic [2:0] seq_state;
`ifdef BACKTRACK_STATS_EN
    logic [7:0] bump_count, abort_count;
`endif

    int total = 0;
    int bad   = 0;
    bit tb_dir = 1'b0;

    always #5 clk = ~clk;

    backtrack_sequencer #(
        .CLK_HZ(10_000), .DEBOUNCE_MS(2), .REVERSE_MS(5), .TURN_MS(3), .COOLDOWN_MS(2)
    ) dut (
        .clk(clk), .rst(rst), .x_bumper(x_bumper), .y_bumper(y_bumper),
        .spi_x(spi_x), .spi_y(spi_y), .spi_valid(spi_valid),
        .out_x(out_x), .out_y(out_y), .out_valid(out_valid),
        .backtrack_active(backtrack_active), .seq_state(seq_state)
`ifdef BACKTRACK_STATS_EN
        , .bump_count(bump_count), .abort_count(abort_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Stay in state st until it changes (bounded); spi strobes every spi_period cycles.
    task automatic run_state(input logic [2:0] st, input int spi_period,
                             output int n, output int pulses, output bit leak);
        n = 0;
        pulses = 0;
        leak = 1'b0;
        do begin
            spi_x = 8'h55;
            spi_y = 8'h66;
            spi_valid = (spi_period > 0) && (n % spi_period == 0);
            step();
            n++;
            if (seq_state == st) begin
                if (out_valid) pulses++;
                if (out_x == 8'h55 || out_y == 8'h66) leak = 1'b1;
            end
        end while (seq_state == st && n < 200);
        spi_valid = 1'b0;
    endtask

    task automatic episode(input bit bounce);
        int n, p;
        bit lk;
        x_bumper = 1'b1;
        y_bumper = 1'b1;
        step();
        chk("deb_enter", seq_state, 1);
        if (bounce) begin
            repeat (7) step();
            chk("deb_hold", seq_state, 1);
            y_bumper = 1'b0;
            step();
            chk("deb_abort", seq_state, 0);
            y_bumper = 1'b1;
            step();
            chk("deb_reenter", seq_state, 1);
        end
        run_state(3'd1, 0, n, p, lk);
        chk("deb_len", (n >= 11 && n <= 20), 1);
        chk("rev_state", seq_state, 2);
        chk("rev_x", out_x, 128);
        chk("rev_y", out_y, 40);
        chk("rev_valid", out_valid, 1);
        chk("rev_active", backtrack_active, 1);

        run_state(3'd2, 3, n, p, lk);
        chk("rev_len", (n >= 41 && n <= 50), 1);
        chk("rev_pulses", p, 4);
        chk("rev_leak", lk, 0);
        chk("turn_state", seq_state, 3);
        chk("turn_x", out_x, tb_dir ? 196 : 60);
        chk("turn_y", out_y, 128);
        chk("turn_valid", out_valid, 1);
        chk("turn_active", backtrack_active, 1);

        run_state(3'd3, 3, n, p, lk);
        chk("turn_len", (n >= 21 && n <= 30), 1);
        chk("turn_pulses", p, 2);
        chk("turn_leak", lk, 0);
        chk("cd_state", seq_state, 4);
        chk("cd_x", out_x, 128);
        chk("cd_y", out_y, 128);
        chk("cd_valid", out_valid, 1);
        chk("cd_active", backtrack_active, 0);

        x_bumper = 1'b0;
        y_bumper = 1'b0;
        run_state(3'd4, 0, n, p, lk);
        chk("cd_len", (n >= 11 && n <= 20), 1);
        chk("cd_pulses", p, 0);
        chk("idle_back", seq_state, 0);
        tb_dir = ~tb_dir;
    endtask

    initial begin
        int n, p;
        bit lk;

        rst = 1'b1;
        step();
        step();
        chk("rst_x", out_x, 128);
        chk("rst_y", out_y, 128);
        chk("rst_valid", out_valid, 0);
        chk("rst_active", backtrack_active, 0);
        chk("rst_state", seq_state, 0);
        rst = 1'b0;
        step();

        // Passthrough with one-cycle latency and a one-cycle strobe.
        spi_x = 8'h10;
        spi_y = 8'hF0;
        spi_valid = 1'b1;
        step();
        spi_valid = 1'b0;
        chk("pass_x", out_x, 8'h10);
        chk("pass_y", out_y, 8'hF0);
        chk("pass_valid", out_valid, 1);
        step();
        chk("pass_valid_drop", out_valid, 0);
        chk("pass_x_hold", out_x, 8'h10);

        episode(1'b0);
        episode(1'b1);
        episode(1'b0);

        // Reset in the middle of REVERSE with turn_dir currently 1.
        chk("dir_before_rst", tb_dir, 1);
        x_bumper = 1'b1;
        y_bumper = 1'b1;
        step();
        run_state(3'd1, 0, n, p, lk);
        repeat (5) step();
        chk("mid_rev", seq_state, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        x_bumper = 1'b0;
        y_bumper = 1'b0;
        tb_dir = 1'b0;
        chk("mrst_x", out_x, 128);
        chk("mrst_y", out_y, 128);
        chk("mrst_active", backtrack_active, 0);
        chk("mrst_state", seq_state, 0);
        chk("mrst_valid", out_valid, 0);
        step();
        chk("mrst_idle", seq_state, 0);

        // turn_dir was cleared, so the next turn is left again.
        episode(1'b1);
`ifdef BACKTRACK_STATS_EN
        episode(1'b1);
        episode(1'b0);
        chk("bump_3", bump_count, 3);
        chk("abort_2", abort_count, 2);
        repeat (253) episode(1'b0);
        chk("bump_sat", bump_count, 255);
        chk("abort_hold", abort_count, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
